button_event_arbiter: RTL and testbench
=======================================

// Module: button_event_arbiter
// PURPOSE
//  Front end for the processor's push-buttons. Synchronizes and debounces N raw
//  button inputs and turns each debounced press into one pending event. A
//  round-robin arbiter offers pending events one at a time to the control unit
//  over a valid/ready handshake. It replaces per-button one-pulse logic wired
//  straight into the control unit.
// PARAMETERS
//  N_BTN         4  number of buttons (>=2)
//  DEBOUNCE_CYC  4  consecutive cycles a synchronized level must differ before it is accepted (>=2)
//  IDW           $clog2(N_BTN)  event id width (derived localparam)
// PORTS
//  Clock       in   1      system clock; all state updates on its rising edge
//  ResetN      in   1      reset, asynchronous, active-low
//  Bi          in   N_BTN  raw asynchronous button levels, 1 = pressed
//  EvReady     in   1      control unit accepts the offered event
//  OverrunClr  in   1      synchronous clear of Overrun
//  EvValid     out  1      an event is offered on EvId
//  EvId        out  IDW    index of the offered button
//  EvPending   out  N_BTN  pending-event bits; not yet granted
//  Overrun     out  1      sticky: a press was lost
// BEHAVIOUR
//  Reset: while ResetN=0, all flops clear asynchronously.
//   - Sync, debounced, pending, counters and EvValid/EvId/EvPending/Overrun are 0.
//   - RR pointer Last=N_BTN-1; FSM goes to IDLE.
//   - A button held through reset release gives exactly one event.
//  Per button i:
//   - 2-FF synchronizer produces s[i].
//   - If s[i]==db[i], cnt[i]<=0.
//   - Otherwise cnt[i] increments; at cnt==DEBOUNCE_CYC-1, db[i]<=s[i] and cnt<=0.
//   - A 0->1 update of db[i] is a press. A press sets pend[i] on that same edge.
//   - Releases generate nothing.
//  Latency (DEBOUNCE_CYC=D): Bi rises before edge 1 and stays stable.
//   - pend set at edge 2+D; EvValid=1 after edge 3+D (edge 7 for D=4).
//  FSM IDLE:
//   - If any pend is set, select g = first set bit searching Last+1, Last+2, ...
//     with wrap mod N_BTN.
//   - Then EvId<=g, EvValid<=1, pend[g]<=0, Last<=g, go to OFFER.
//   - If no pend is set, EvValid=0.
//  FSM OFFER:
//   - EvValid and EvId hold stable until EvValid&&EvReady.
//   - On that edge, EvValid<=0 and go to IDLE.
//   - Peak rate is one event per 2 cycles. EvReady while EvValid=0 is ignored.
//  Simultaneous set and clear of pend[i] on the same edge: set wins, no overrun.
//  Overrun: a press on i while pend[i]=1 (and pend[i] not cleared that edge)
//  sets Overrun. The pending bit stays 1, so the press merges.
//  OverrunClr=1 clears Overrun; a coincident new overrun wins.
//  EvPending = pend register. EvId keeps its last value while EvValid=0.
// CONFIGURATION
//  BTN_FIXED_PRIO_EN defined:
//   - IDLE grants the lowest set pend index.
//   - Last is unused and may be removed. All else is unchanged.
//  BTN_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
//  1 Reset mid-OFFER (EvValid=1, EvId=2, Overrun=1): ResetN=0 -> all outputs 0
//    before the next edge.
//  2 Bounce: Bi[0] toggles every cycle for 8 cycles, then 0 -> EvValid never 1,
//    EvPending stays 0.
//  3 Bi[1]=1 held 20 cycles, EvReady=1 -> EvValid=1 for exactly 1 cycle after
//    edge 7 with EvId=1; no repeat while held.
//  4 Bi[0] and Bi[2] rise together, EvReady=1 -> events id 0 then id 2, two
//    cycles apart.
//    Then Bi[0] and Bi[3] rise together (Last=2) -> id 3 then 0.
//    With BTN_FIXED_PRIO_EN -> id 0 then 3.
//  5 EvReady=0; press Bi[1] -> OFFER holds EvId=1 and pend[1]=0.
//    Release >=D+2 cycles, press -> pend[1]=1.
//    Release, press again -> Overrun=1, pend[1] still 1.
//    Pulse OverrunClr -> Overrun=0.
//    Raise EvReady -> id 1 accepted, then id 1 again 2 cycles later.
//  6 pend[3] granted on the same edge a new Bi[3] press lands -> pend[3]=1 after
//    that edge, Overrun=0.

Source files
------------

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: synchronizes and debounces N push-buttons, queues one pending event per press,
// and offers the pending events one at a time over EvValid/EvReady. Optional macro BTN_FIXED_PRIO_EN
// switches the grant order from round-robin to lowest index first. Latency: raw edge to pending is
// DEBOUNCE_CYC+2 cycles, and pending to EvValid is 1 more. Backpressure: EvValid/EvId hold until
// EvReady. Presses that arrive while a button is already pending merge and set the sticky Overrun.
module button_event_arbiter #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 4,
  localparam int IDW         = $clog2(N_BTN)
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic [N_BTN-1:0] Bi,
  input  logic             EvReady,
  input  logic             OverrunClr,
  output logic             EvValid,
  output logic [IDW-1:0]   EvId,
  output logic [N_BTN-1:0] EvPending,
  output logic             Overrun
);

  // The debounce counter only has to reach DEBOUNCE_CYC-1.
  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;
  logic [N_BTN-1:0] db;
  logic [CW-1:0]    cnt [N_BTN];
  logic [N_BTN-1:0] press;
  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] grant_clr;
  logic             overrun;

  state_t           state;
  state_t           state_nxt;
  logic             ev_valid;
  logic             ev_valid_nxt;
  logic [IDW-1:0]   ev_id;
  logic [IDW-1:0]   ev_id_nxt;
  logic [IDW-1:0]   gnt_id;

`ifndef BTN_FIXED_PRIO_EN
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   last_nxt;
  logic [IDW-1:0]   cand;
`endif

  // Two-flop synchronizer for the raw, asynchronous button levels.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= Bi;
      sync2 <= sync1;
    end
  end

  // A new level is accepted only after it has differed from the debounced level
  // for DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts the count.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      db <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press is the cycle where the debounced level is about to flip from 0 to 1.
  always_comb begin
    press = '0;
    for (int i = 0; i < N_BTN; i++) begin
      press[i] = sync2[i] && !db[i] && (cnt[i] == CNT_MAX);
    end
  end

`ifdef BTN_FIXED_PRIO_EN
  // Grant candidate: the lowest pending index.
  always_comb begin
    gnt_id = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (pend[k]) begin
        gnt_id = IDW'(k);
      end
    end
  end
`else
  // Grant candidate: the first pending index after the last grant, with wrap-around.
  // The loop runs from the far end so that the nearest hit is written last.
  always_comb begin
    gnt_id = '0;
    cand   = '0;
    for (int k = N_BTN; k >= 1; k--) begin
      cand = IDW'((int'(last) + k) % N_BTN);
      if (pend[cand]) begin
        gnt_id = cand;
      end
    end
  end
`endif

  // Offer FSM next state: IDLE grants one pending bit and OFFER waits for the handshake.
  always_comb begin
    state_nxt    = state;
    ev_valid_nxt = ev_valid;
    ev_id_nxt    = ev_id;
    grant_clr    = '0;
`ifndef BTN_FIXED_PRIO_EN
    last_nxt     = last;
`endif
    case (state)
      IDLE: begin
        if (|pend) begin
          ev_valid_nxt      = 1'b1;
          ev_id_nxt         = gnt_id;
          grant_clr[gnt_id] = 1'b1;
`ifndef BTN_FIXED_PRIO_EN
          last_nxt          = gnt_id;
`endif
          state_nxt         = OFFER;
        end else begin
          ev_valid_nxt = 1'b0;
        end
      end
      OFFER: begin
        if (ev_valid && EvReady) begin
          ev_valid_nxt = 1'b0;
          state_nxt    = IDLE;
        end
      end
      default: begin
        ev_valid_nxt = 1'b0;
        state_nxt    = IDLE;
      end
    endcase
  end

  // Offer FSM registers. EvId keeps its value after the handshake.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state    <= IDLE;
      ev_valid <= 1'b0;
      ev_id    <= '0;
`ifndef BTN_FIXED_PRIO_EN
      last     <= IDW'(N_BTN - 1);
`endif
    end else begin
      state    <= state_nxt;
      ev_valid <= ev_valid_nxt;
      ev_id    <= ev_id_nxt;
`ifndef BTN_FIXED_PRIO_EN
      last     <= last_nxt;
`endif
    end
  end

  // Pending bits are set by a press and cleared by a grant, and a set on the same edge wins.
  // A press that lands on a bit that is still pending is lost and makes Overrun sticky.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      pend    <= '0;
      overrun <= 1'b0;
    end else begin
      pend    <= (pend & ~grant_clr) | press;
      overrun <= (|(press & pend & ~grant_clr)) | (overrun & ~OverrunClr);
    end
  end

  assign EvValid   = ev_valid;
  assign EvId      = ev_id;
  assign EvPending = pend;
  assign Overrun   = overrun;

  // The offered event must not change until it is accepted.
  a_offer_hold: assert property (@(posedge Clock) disable iff (!ResetN)
    (ev_valid && !EvReady) |=> (ev_valid && $stable(ev_id)));

  // EvValid is asserted only while the FSM is in OFFER.
  a_valid_state: assert property (@(posedge Clock) disable iff (!ResetN)
    ev_valid == (state == OFFER));

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: randomized and directed stimulus for button_event_arbiter.
// A behavioural model produces the expected outputs, and they are compared on every falling edge.
// Directed scenarios add hand-computed expectations for latency, ordering, merging and reset.
module tb_button_event_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic         Clock = 1'b0;
  logic         ResetN = 1'b0;
  logic [N-1:0] Bi = '0;
  logic         EvReady = 1'b0;
  logic         OverrunClr = 1'b0;
  logic         EvValid;
  logic [1:0]   EvId;
  logic [N-1:0] EvPending;
  logic         Overrun;

  int total = 0;
  int bad   = 0;

  button_event_arbiter #(.N_BTN(N), .DEBOUNCE_CYC(D)) dut (
    .Clock(Clock), .ResetN(ResetN), .Bi(Bi), .EvReady(EvReady), .OverrunClr(OverrunClr),
    .EvValid(EvValid), .EvId(EvId), .EvPending(EvPending), .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps the sampled history of each button and the length of the current run of
  // samples that disagree with the accepted level. It also keeps the set of waiting presses and
  // the event currently offered.
  logic [N-1:0] m_s1, m_s2, m_db, m_pend, m_press, m_clr;
  int           m_run [N];
  logic         m_off, m_ovr;
  int           m_id, m_last, m_pick;

  function automatic int pick(input logic [N-1:0] p, input int lst);
    int r;
    r = -1;
`ifdef BTN_FIXED_PRIO_EN
    for (int k = N - 1; k >= 0; k--)
      if (((p >> k) & 1) != 0) r = k;
`else
    for (int k = N; k >= 1; k--)
      if (((p >> ((lst + k) % N)) & 1) != 0) r = (lst + k) % N;
`endif
    return r;
  endfunction

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_pend = '0;
      m_off = 1'b0; m_ovr = 1'b0; m_id = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      m_press = '0;
      m_clr   = '0;
      for (int i = 0; i < N; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == D) begin
            m_db[i]    = m_s2[i];
            m_run[i]   = 0;
            m_press[i] = m_s2[i];
          end
        end else begin
          m_run[i] = 0;
        end
      end
      if (m_off) begin
        if (EvReady) m_off = 1'b0;
      end else if (m_pend != 0) begin
        m_pick = pick(m_pend, m_last);
        m_off  = 1'b1;
        m_id   = m_pick;
        m_last = m_pick;
        m_clr  = N'(1) << m_pick;
      end
      m_ovr  = ((m_press & m_pend & ~m_clr) != 0) || (m_ovr && !OverrunClr);
      m_pend = (m_pend & ~m_clr) | m_press;
      m_s2   = m_s1;
      m_s1   = Bi;
    end
  end

  // One compare process, away from the active edge.
  always @(negedge Clock) begin
    check("cmp_valid",   32'(EvValid),   32'(m_off));
    check("cmp_id",      32'(EvId),      32'(m_id));
    check("cmp_pending", 32'(EvPending), 32'(m_pend));
    check("cmp_overrun", 32'(Overrun),   32'(m_ovr));
  end

  // ---------------- directed helpers ----------------
  int q_id[$];
  int q_cyc[$];

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #2;
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k;
    k = 0;
    while (EvValid !== 1'b1 && k < budget) begin
      tick(1);
      k++;
    end
    check(name, 32'(EvValid), 32'd1);
  endtask

  task automatic record(input int n);
    q_id.delete();
    q_cyc.delete();
    for (int c = 0; c < n; c++) begin
      if (EvValid === 1'b1 && EvReady === 1'b1) begin
        q_id.push_back(int'(EvId));
        q_cyc.push_back(c);
      end
      tick(1);
    end
  endtask

  int first, nval, idv, seen;

  initial begin
    // Outputs come out of reset at zero.
    tick(3);
    check("rst_valid", 32'(EvValid), 32'd0);
    check("rst_pending", 32'(EvPending), 32'd0);
    check("rst_overrun", 32'(Overrun), 32'd0);
    ResetN = 1'b1;
    tick(2);

    // Latency and single event for a held button.
    EvReady = 1'b1;
    Bi = 4'b0010;
    first = 0; nval = 0; idv = -1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (EvValid === 1'b1) begin
        nval++;
        if (first == 0) begin
          first = c;
          idv = int'(EvId);
        end
      end
    end
    check("t3_first_edge", 32'(first), 32'd7);
    check("t3_count", 32'(nval), 32'd1);
    check("t3_id", 32'(idv), 32'd1);
    Bi = '0;
    tick(D + 4);

    // Bounce never produces an event.
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      Bi[0] = ~Bi[0];
      tick(1);
      if (EvValid !== 1'b0 || EvPending !== '0) seen++;
    end
    Bi = '0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (EvValid !== 1'b0 || EvPending !== '0) seen++;
    end
    check("t2_bounce", 32'(seen), 32'd0);

    // Simultaneous presses are granted in arbitration order.
    ResetN = 1'b0;
    tick(2);
    ResetN = 1'b1;
    tick(2);
    Bi = 4'b0101;
    record(20);
    check("t4a_n", 32'(q_id.size()), 32'd2);
    if (q_id.size() == 2) begin
      check("t4a_id0", 32'(q_id[0]), 32'd0);
      check("t4a_id1", 32'(q_id[1]), 32'd2);
      check("t4a_gap", 32'(q_cyc[1] - q_cyc[0]), 32'd2);
    end
    Bi = '0;
    tick(D + 4);
    Bi = 4'b1001;
    record(20);
    check("t4b_n", 32'(q_id.size()), 32'd2);
    if (q_id.size() == 2) begin
`ifdef BTN_FIXED_PRIO_EN
      check("t4b_id0", 32'(q_id[0]), 32'd0);
      check("t4b_id1", 32'(q_id[1]), 32'd3);
`else
      check("t4b_id0", 32'(q_id[0]), 32'd3);
      check("t4b_id1", 32'(q_id[1]), 32'd0);
`endif
    end
    Bi = '0;
    tick(D + 4);

    // Backpressure, pending, merge and overrun clear.
    EvReady = 1'b0;
    Bi = 4'b0010;
    wait_valid(20, "t5_valid");
    check("t5_id", 32'(EvId), 32'd1);
    check("t5_pend_clr", 32'(EvPending[1]), 32'd0);
    Bi = '0;
    tick(D + 3);
    Bi = 4'b0010;
    tick(D + 4);
    check("t5_pend_set", 32'(EvPending[1]), 32'd1);
    check("t5_no_ovr", 32'(Overrun), 32'd0);
    check("t5_hold_id", 32'(EvId), 32'd1);
    Bi = '0;
    tick(D + 3);
    Bi = 4'b0010;
    tick(D + 4);
    check("t5_ovr", 32'(Overrun), 32'd1);
    check("t5_pend_merge", 32'(EvPending[1]), 32'd1);
    OverrunClr = 1'b1;
    tick(1);
    OverrunClr = 1'b0;
    check("t5_ovr_clr", 32'(Overrun), 32'd0);
    EvReady = 1'b1;
    record(8);
    check("t5_n", 32'(q_id.size()), 32'd2);
    if (q_id.size() == 2) begin
      check("t5_id0", 32'(q_id[0]), 32'd1);
      check("t5_id1", 32'(q_id[1]), 32'd1);
      check("t5_gap", 32'(q_cyc[1] - q_cyc[0]), 32'd2);
    end

    // Grant and new press on the same edge: set wins, no overrun.
    EvReady = 1'b0;
    Bi = '0;
    tick(D + 4);
    Bi = 4'b0100;
    wait_valid(20, "t6_valid");
    check("t6_id2", 32'(EvId), 32'd2);
    Bi = 4'b1100;
    tick(D + 4);
    check("t6_pend3", 32'(EvPending[3]), 32'd1);
    Bi = 4'b0100;
    tick(D + 4);
    Bi = 4'b1100;
    tick(4);
    EvReady = 1'b1;
    tick(1);
    tick(1);
    check("t6_pend_kept", 32'(EvPending[3]), 32'd1);
    check("t6_no_ovr", 32'(Overrun), 32'd0);
    check("t6_granted", 32'(EvId), 32'd3);

    // Reset in the middle of an offer with Overrun set.
    Bi = '0;
    tick(D + 8);
    EvReady = 1'b0;
    Bi = 4'b0100;
    wait_valid(20, "t1_valid");
    Bi = '0;
    tick(D + 3);
    Bi = 4'b0100;
    tick(D + 4);
    Bi = '0;
    tick(D + 3);
    Bi = 4'b0100;
    tick(D + 4);
    check("t1_pre_valid", 32'(EvValid), 32'd1);
    check("t1_pre_id", 32'(EvId), 32'd2);
    check("t1_pre_ovr", 32'(Overrun), 32'd1);
    ResetN = 1'b0;
    #1;
    check("t1_valid", 32'(EvValid), 32'd0);
    check("t1_id", 32'(EvId), 32'd0);
    check("t1_pending", 32'(EvPending), 32'd0);
    check("t1_ovr", 32'(Overrun), 32'd0);
    tick(2);
    ResetN = 1'b1;

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 9) == 0) Bi[i] = ~Bi[i];
      EvReady    = (c < 2000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      OverrunClr = ($urandom_range(0, 15) == 0);
      ResetN     = ($urandom_range(0, 799) != 0);
      tick(1);
    end
    ResetN = 1'b1;
    Bi = '0;
    EvReady = 1'b1;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
